mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU.
- Consumes the same ID/EX operands and 6-bit func field as the ALU.
- Owns the architectural HI/LO registers.
- Feeds HI/LO into the EX result mux downstream of the ALU, and raises busy so the hazard unit stalls IF/ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 5, iteration counter width; WIDTH must equal 2**CNT_W.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; one clock domain only
- start  input  1  ID/EX holds a valid MDU instruction this cycle
- flush  input  1  kill the in-flight operation (branch/exception)
- func  input  6  MIPS funct field: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
- data_a  input  WIDTH  rs operand (multiplicand/dividend, MTHI/MTLO source)
- data_b  input  WIDTH  rt operand (multiplier/divisor)
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register
- mf_result  output  WIDTH  combinational: hi when func==MFHI, lo when func==MFLO, else 0
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse when HI/LO receive a new mult/div result

Behaviour:
- Reset (reset==0, asynchronous):
  - State IDLE; hi, lo, count, done and internal accumulators all 0.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, func in {MULT, MULTU, DIV, DIVU}, edge E0:
  - Latch operands.
  - For signed ops, convert operands to magnitudes and record the result signs.
  - Set count=0; go to RUN.
- RUN:
  - One radix-2 step per edge: shift-add for multiply, restoring subtract-shift for divide.
  - count increments each edge.
  - The step taken at count==WIDTH-1 (edge E32) moves to FIX.
- FIX, edge E33:
  - Apply sign correction; write hi/lo; done=1 for the following cycle; go to IDLE.
  - busy is high for exactly 33 cycles after E0.
  - A new start is accepted on the edge where done is high.
- Multiply: {hi,lo} = full 64-bit product.
  - Signed product is negated when the operand signs differ.
- Divide: lo = quotient, hi = remainder.
  - Signed: quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
  - 0x80000000 / 0xFFFFFFFF (DIV) -> lo=0x80000000, hi=0 (wraps, no trap).
  - Divisor==0 (DIV or DIVU) -> lo=0xFFFFFFFF, hi=data_a. Still takes the full 33 cycles; done pulses.
- MTHI/MTLO with start=1 in IDLE:
  - hi/lo <= data_a on that edge; no busy, no done.
- MFHI/MFLO:
  - Purely combinational via mf_result; no state change.
- start while busy:
  - Ignored (hazard unit must stall). MTHI/MTLO while busy are also ignored.
- flush=1 in RUN or FIX:
  - Next edge state=IDLE; hi/lo unchanged; no done.
  - flush has priority over start on the same edge.
- flush and reset mid-operation:
  - Both abort cleanly.
  - Reset additionally clears hi/lo.
- Unknown func with start=1:
  - No effect.

Optional Feature:
- Macro: MUSA_MDU_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle combinational 64-bit multiplier.
  - Result is written at E1, with done high the following cycle.
  - busy is high for one cycle only.
  - DIV/DIVU are unchanged (33 cycles).
- Undefined:
  - All four ops are iterative, as specified above.

Decomposition:
- musa_pkg (shared package) holds:
  - funct code constants (FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO), also used by the ALU/control decode
  - FSM state encoding
  - WIDTH default
- One natural sub-module, mdu_step:
  - Combinational single-iteration datapath taking {acc, operand, mode} -> next acc.
  - Instanced once inside mdu_iter, which keeps the FSM, counter, sign handling and HI/LO.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 34 after start; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
2. MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21). DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100, done pulses. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI 0x1234 then MFHI -> mf_result=0x1234 the next cycle. start MULT during busy -> ignored; hi/lo reflect the first op only.
5. DIVU 50/7 then flush at count 10 -> busy falls the next cycle, hi/lo keep prior values, no done. Reset low mid-RUN -> all outputs 0 immediately (asynchronous).
6. With MUSA_MDU_FAST_MUL_EN: MULTU 3x5 -> lo=15, hi=0, done one cycle after the start edge; DIVU 15/4 still 33 cycles (lo=3, hi=3).

Source files
------------

// File: rtl/musa_pkg.sv
// musa_pkg: shared MIPS funct codes, MDU state encoding and default datapath width.
package musa_pkg;
  localparam int MDU_WIDTH = 32;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} mdu_state_e;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration on acc = {upper, lower}; shift-add multiply or
// restoring subtract-shift divide (upper = partial remainder, lower = quotient/dividend).
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               div_i,
  output logic [2*WIDTH-1:0] acc_o
);
  logic [WIDTH:0] sum, rem, diff;
  assign sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opb_i : {WIDTH{1'b0}})};
  assign rem  = acc_i[2*WIDTH-1:WIDTH-1];
  // rem < 2*divisor always holds, so diff[WIDTH] is exactly the borrow
  assign diff = rem - {1'b0, opb_i};
  assign acc_o = div_i ? {(diff[WIDTH] ? rem[WIDTH-1:0] : diff[WIDTH-1:0]), acc_i[WIDTH-2:0], ~diff[WIDTH]}
                       : {sum, acc_i[WIDTH-1:1]};
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit owning HI/LO; MUSA_MDU_FAST_MUL_EN
// swaps the iterative multiply for a single-cycle combinational one.
module mdu_iter import musa_pkg::*; #(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_result,
  output logic             busy,
  output logic             done
);
  mdu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step, res_mul;
  logic [WIDTH-1:0] opb_q, opb_d, hi_q, hi_d, lo_q, lo_d, mag_a, mag_b, q_fix, r_fix;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
  logic is_mul, is_div, sgn, sa, sb;
  assign is_mul = func == FN_MULT || func == FN_MULTU;
  assign is_div = func == FN_DIV || func == FN_DIVU;
  assign sgn    = func == FN_MULT || func == FN_DIV;
  // a zero divisor keeps the raw dividend so the unsigned core yields q=all-ones, r=data_a
  assign sa     = sgn && data_a[WIDTH-1] && !(is_div && data_b == '0);
  assign sb     = sgn && data_b[WIDTH-1];
  assign mag_a  = sa ? -data_a : data_a;
  assign mag_b  = sb ? -data_b : data_b;
  assign res_mul = neg_q ? -acc_q : acc_q;
  assign q_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign r_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`ifdef MUSA_MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif
  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_i(acc_q),
    .opb_i(opb_q),
    .div_i(div_q),
    .acc_o(acc_step)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (flush) state_d = ST_IDLE;
    else case (state_q)
      ST_IDLE: if (start) begin
        if (is_mul || is_div) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          acc_d   = {{WIDTH{1'b0}}, mag_a};
          opb_d   = mag_b;
          div_d   = is_div;
          neg_d   = sa ^ sb;
          rneg_d  = sa;
`ifdef MUSA_MDU_FAST_MUL_EN
          if (is_mul) begin
            state_d = ST_FIX;
            acc_d   = prod;
          end
`endif
        end
        if (func == FN_MTHI) hi_d = data_a;
        if (func == FN_MTLO) lo_d = data_a;
      end
      ST_RUN: begin
        acc_d   = acc_step;
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? ST_FIX : ST_RUN;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        {hi_d, lo_d} = div_q ? {r_fix, q_fix} : res_mul;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = state_q != ST_IDLE;
  assign done      = done_q;
  assign mf_result = func == FN_MFHI ? hi_q : func == FN_MFLO ? lo_q : '0;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed scoreboard bench for mdu_iter; expected HI:LO values are
// queued at issue and popped when done pulses.
module tb_mdu_iter;
  import musa_pkg::*;
  localparam int W = 32;
`ifdef MUSA_MDU_FAST_MUL_EN
  localparam int MUL_BUSY = 1;
`else
  localparam int MUL_BUSY = 33;
`endif
  logic clock = 1'b0, reset = 1'b0, start = 1'b0, flush = 1'b0;
  logic [5:0] func = 6'h00;
  logic [W-1:0] data_a = '0, data_b = '0;
  logic [W-1:0] hi, lo, mf_result;
  logic busy, done;
  int checks = 0, errors = 0;
  logic [63:0] sb_q[$];
  always #5 clock = ~clock;
  mdu_iter dut (
    .clock(clock), .reset(reset), .start(start), .flush(flush), .func(func),
    .data_a(data_a), .data_b(data_b), .hi(hi), .lo(lo), .mf_result(mf_result),
    .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [63:0] exp, input bit push);
    func = f; data_a = a; data_b = b; start = 1'b1;
    if (push) sb_q.push_back(exp);
    @(negedge clock);
    start = 1'b0; func = 6'h00;
  endtask
  task automatic finish_op(input string tag, input int exp_busy);
    int cyc = 0, bc = 0;
    logic [63:0] e;
    while (!done && cyc < 200) begin
      bc += int'(busy);
      @(negedge clock);
      cyc++;
    end
    check({tag, " done"}, 64'(done), 64'd1);
    check({tag, " busy cycles"}, 64'(bc), 64'(exp_busy));
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    check({tag, " hi:lo"}, {hi, lo}, e);
  endtask
  initial begin
    int seen;
    @(negedge clock); @(negedge clock);
    func = FN_MFHI;
    #1;
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset mf", 64'(mf_result), 64'd0);
    @(negedge clock);
    reset = 1'b1; func = 6'h00;
    @(negedge clock);
    issue(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
    finish_op("multu max", MUL_BUSY);
    @(negedge clock);
    check("done pulse width", 64'(done), 64'd0);
    issue(FN_MULT, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, 1'b1);
    finish_op("mult neg", MUL_BUSY);
    issue(FN_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b1);
    finish_op("div neg", 33);
    issue(FN_DIVU, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, 1'b1);
    finish_op("divu by zero", 33);
    issue(FN_DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b1);
    finish_op("div overflow", 33);
    issue(FN_DIVU, 32'd15, 32'd4, 64'h00000003_00000003, 1'b1);
    finish_op("divu back-to-back", 33);
    issue(FN_MTHI, 32'h1234, 32'd0, 64'd0, 1'b0);
    check("mthi busy", 64'(busy), 64'd0);
    check("mthi done", 64'(done), 64'd0);
    func = FN_MFHI;
    #1 check("mfhi", 64'(mf_result), 64'h1234);
    check("mthi keeps lo", 64'(lo), 64'd3);
    @(negedge clock);
    issue(FN_MTLO, 32'h5678, 32'd0, 64'd0, 1'b0);
    func = FN_MFLO;
    #1 check("mflo", 64'(mf_result), 64'h5678);
    func = FN_MULT;
    #1 check("mf other func", 64'(mf_result), 64'd0);
    @(negedge clock);
    issue(6'h3F, 32'hAAAA, 32'hBBBB, 64'd0, 1'b0);
    check("unknown busy", 64'(busy), 64'd0);
    check("unknown hi:lo", {hi, lo}, 64'h00001234_00005678);
    issue(FN_DIVU, 32'd42, 32'd1, 64'h00000000_0000002A, 1'b1);
    repeat (3) @(negedge clock);
    start = 1'b1; func = FN_MULT; data_a = 32'd9; data_b = 32'd9;
    @(negedge clock);
    func = FN_MTHI; data_a = 32'hDEAD;
    @(negedge clock);
    start = 1'b0; func = 6'h00;
    finish_op("start while busy", 28);
    issue(FN_DIVU, 32'd50, 32'd7, 64'd0, 1'b0);
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush hi:lo", {hi, lo}, 64'h00000000_0000002A);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      seen |= int'(done);
    end
    check("flush no done", 64'(seen), 64'd0);
    issue(FN_DIVU, 32'd1000, 32'd3, 64'd0, 1'b0);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async reset hi", 64'(hi), 64'd0);
    check("async reset lo", 64'(lo), 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post reset busy", 64'(busy), 64'd0);
    issue(FN_MULTU, 32'd3, 32'd5, 64'h00000000_0000000F, 1'b1);
    finish_op("multu small", MUL_BUSY);
    check("scoreboard empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
